// File: rtl/mem_comp_queue.sv
// MEM->COMPLETE completion queue: two writers per cycle (LSQ first, then MEM), FWFT head, 1-cycle latency when empty.
// Backpressure: comp_ready stalls the head; almost_full asks upstream to hold; rejected inputs set sticky overflow.
module mem_comp_queue #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int TAG_W  = 6,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              lsq_valid,
  input  logic [DATA_W-1:0] lsq_data,
  input  logic [PC_W-1:0]   lsq_pc,
  input  logic [TAG_W-1:0]  lsq_tag,
  input  logic              lsq_is_store,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [PC_W-1:0]   mem_pc,
  input  logic [TAG_W-1:0]  mem_tag,
  input  logic              mem_is_store,
  input  logic              comp_ready,
  output logic              comp_valid,
  output logic [DATA_W-1:0] comp_data,
  output logic [PC_W-1:0]   comp_pc,
  output logic [TAG_W-1:0]  comp_tag,
  output logic              comp_is_store,
  output logic              comp_from_lsq,
  output logic              almost_full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
    logic [TAG_W-1:0]  tag;
    logic              is_store;
    logic              from_lsq;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  entry_t           w_head;
  entry_t           w_lsq_ent;
  entry_t           w_mem_ent;
  logic             w_deq;
  logic [CNT_W:0]   w_space;
  logic [CNT_W:0]   w_mem_need;
  logic             w_lsq_acc;
  logic             w_mem_acc;
  logic [1:0]       w_acc_cnt;
  logic             w_drop;
  logic [PTR_W-1:0] w_mem_ptr;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_lsq_ent = '{data: lsq_data, pc: lsq_pc, tag: lsq_tag, is_store: lsq_is_store, from_lsq: 1'b1};
  assign w_mem_ent = '{data: mem_data, pc: mem_pc, tag: mem_tag, is_store: mem_is_store, from_lsq: 1'b0};

  assign w_head        = r_mem[r_rd_ptr];
  assign comp_valid    = (r_count != '0);
  assign comp_data     = w_head.data;
  assign comp_pc       = w_head.pc;
  assign comp_tag      = w_head.tag;
  assign comp_is_store = w_head.is_store;
  assign comp_from_lsq = w_head.from_lsq;
  assign count         = r_count;
  assign overflow      = r_overflow;
  assign almost_full   = (r_count >= CNT_W'(DEPTH - 1));

  // A slot leaving this cycle is reusable by a same-cycle write.
  assign w_deq      = comp_valid & comp_ready;
  assign w_space    = (CNT_W+1)'(DEPTH) - {1'b0, r_count} + {{CNT_W{1'b0}}, w_deq};
  assign w_lsq_acc  = lsq_valid & (w_space != '0);
  assign w_mem_need = (CNT_W+1)'(1) + {{CNT_W{1'b0}}, w_lsq_acc};
  assign w_mem_acc  = mem_valid & (w_space >= w_mem_need);
  assign w_acc_cnt  = {1'b0, w_lsq_acc} + {1'b0, w_mem_acc};
  assign w_drop     = (lsq_valid & ~w_lsq_acc) | (mem_valid & ~w_mem_acc);

  assign w_mem_ptr    = r_wr_ptr + PTR_W'(w_lsq_acc);
  assign w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_acc_cnt);
  assign w_count_nxt  = r_count + CNT_W'(w_acc_cnt) - CNT_W'(w_deq);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (!flush) begin
      if (w_lsq_acc) r_mem[r_wr_ptr] <= w_lsq_ent;
      if (w_mem_acc) r_mem[w_mem_ptr] <= w_mem_ent;
    end
  end

endmodule

// File: tb/tb_mem_comp_queue.sv
// Directed bench for mem_comp_queue: stimulus pushes expected head entries, a negedge monitor pops and compares.
module tb_mem_comp_queue;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int TAG_W  = 6;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
    logic [TAG_W-1:0]  tag;
    logic              is_store;
    logic              from_lsq;
  } exp_t;

  logic              clk = 1'b0;
  logic              rstn;
  logic              flush;
  logic              lsq_valid, mem_valid;
  logic [DATA_W-1:0] lsq_data, mem_data;
  logic [PC_W-1:0]   lsq_pc, mem_pc;
  logic [TAG_W-1:0]  lsq_tag, mem_tag;
  logic              lsq_is_store, mem_is_store;
  logic              comp_ready;
  logic              comp_valid;
  logic [DATA_W-1:0] comp_data;
  logic [PC_W-1:0]   comp_pc;
  logic [TAG_W-1:0]  comp_tag;
  logic              comp_is_store;
  logic              comp_from_lsq;
  logic              almost_full;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mem_comp_queue #(.DATA_W(DATA_W), .PC_W(PC_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .lsq_valid(lsq_valid), .lsq_data(lsq_data), .lsq_pc(lsq_pc), .lsq_tag(lsq_tag), .lsq_is_store(lsq_is_store),
    .mem_valid(mem_valid), .mem_data(mem_data), .mem_pc(mem_pc), .mem_tag(mem_tag), .mem_is_store(mem_is_store),
    .comp_ready(comp_ready), .comp_valid(comp_valid), .comp_data(comp_data), .comp_pc(comp_pc),
    .comp_tag(comp_tag), .comp_is_store(comp_is_store), .comp_from_lsq(comp_from_lsq),
    .almost_full(almost_full), .count(count), .overflow(overflow)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lsq(input logic v, input logic [31:0] d, input logic [31:0] pc,
                         input logic [5:0] tag, input logic st, input logic push);
    lsq_valid = v; lsq_data = d; lsq_pc = pc; lsq_tag = tag; lsq_is_store = st;
    if (push) exp_q.push_back('{data: d, pc: pc, tag: tag, is_store: st, from_lsq: 1'b1});
  endtask

  task automatic set_mem(input logic v, input logic [31:0] d, input logic [31:0] pc,
                         input logic [5:0] tag, input logic st, input logic push);
    mem_valid = v; mem_data = d; mem_pc = pc; mem_tag = tag; mem_is_store = st;
    if (push) exp_q.push_back('{data: d, pc: pc, tag: tag, is_store: st, from_lsq: 1'b0});
  endtask

  // Every handshake that will dequeue at the next edge must match the oldest expected entry.
  always @(negedge clk) begin
    if (rstn && !flush && comp_valid && comp_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL head_unexpected: got tag %0h with no entry expected (t=%0t)", comp_tag, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("head_entry", {comp_data, comp_pc, comp_tag, comp_is_store, comp_from_lsq}, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; flush = 1'b0; comp_ready = 1'b0;
    set_lsq(0, 0, 0, 0, 0, 0);
    set_mem(0, 0, 0, 0, 0, 0);
    #3;
    check("rst_count", count, 0);
    check("rst_valid", comp_valid, 0);
    check("rst_af", almost_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_head", {comp_data, comp_pc, comp_tag, comp_is_store, comp_from_lsq}, 0);
    #10 rstn = 1'b1;
    cyc();

    // Single MEM load, comp_ready high: visible one edge after acceptance.
    comp_ready = 1'b1;
    set_mem(1, 32'hDEADBEEF, 32'h100, 3, 0, 1);
    cyc();
    set_mem(0, 0, 0, 0, 0, 0);
    check("t1_valid", comp_valid, 1);
    check("t1_count", count, 1);
    cyc();
    check("t1_count_after", count, 0);

    // Both sources in one cycle: LSQ ahead of MEM.
    comp_ready = 1'b0;
    set_lsq(1, 32'h11, 32'h200, 1, 0, 1);
    set_mem(1, 32'h22, 32'h204, 2, 1, 1);
    cyc();
    set_lsq(0, 0, 0, 0, 0, 0);
    set_mem(0, 0, 0, 0, 0, 0);
    check("t2_count", count, 2);
    comp_ready = 1'b1;
    cyc();
    cyc();
    comp_ready = 1'b0;
    check("t2_count_drained", count, 0);

    // Flush with an input pending: nothing stored, overflow untouched.
    for (int i = 0; i < 3; i++) begin
      set_mem(1, 32'h3000 + i, 32'h400 + 4 * i, 6'(30 + i), 0, 0);
      cyc();
    end
    set_mem(0, 0, 0, 0, 0, 0);
    check("t5_count_pre", count, 3);
    check("t5_af_pre", almost_full, 1);
    flush = 1'b1;
    set_lsq(1, 32'h33, 32'h40C, 33, 0, 0);
    cyc();
    flush = 1'b0;
    set_lsq(0, 0, 0, 0, 0, 0);
    check("t5_count", count, 0);
    check("t5_valid", comp_valid, 0);
    check("t5_ovf", overflow, 0);
    cyc();
    check("t5_valid_later", comp_valid, 0);

    // Fill to full, overflow on a 5th, then stream through the pointer wrap.
    for (int i = 0; i < 4; i++) begin
      set_mem(1, 32'h1000 + i, 32'h300 + 4 * i, 6'(i), 0, 1);
      cyc();
      check("t3_fill_count", count, i + 1);
      check("t3_fill_af", almost_full, (i + 1 >= 3) ? 1 : 0);
    end
    set_mem(1, 32'h1009, 32'h3F0, 9, 0, 0);
    cyc();
    check("t3_ovf", overflow, 1);
    check("t3_full_count", count, 4);
    comp_ready = 1'b1;
    for (int i = 4; i < 8; i++) begin
      set_mem(1, 32'h1000 + i, 32'h300 + 4 * i, 6'(i), 0, 1);
      cyc();
    end
    set_mem(0, 0, 0, 0, 0, 0);
    check("t3_stream_count", count, 4);
    cyc();
    cyc();
    comp_ready = 1'b0;
    check("t3_partial_count", count, 2);

    // Asynchronous reset between edges with two entries and overflow set.
    rstn = 1'b0;
    #1;
    check("t6_count", count, 0);
    check("t6_valid", comp_valid, 0);
    check("t6_ovf", overflow, 0);
    check("t6_af", almost_full, 0);
    exp_q.delete();
    #1 rstn = 1'b1;
    cyc();

    // Full with a dequeue: LSQ wins the single free slot, MEM is dropped.
    for (int i = 0; i < 4; i++) begin
      set_mem(1, 32'h5000 + i, 32'h500 + 4 * i, 6'(10 + i), 0, 1);
      cyc();
    end
    check("t4_ovf_pre", overflow, 0);
    comp_ready = 1'b1;
    set_lsq(1, 32'h5020, 32'h520, 20, 1, 1);
    set_mem(1, 32'h5021, 32'h524, 21, 0, 0);
    cyc();
    set_lsq(0, 0, 0, 0, 0, 0);
    set_mem(0, 0, 0, 0, 0, 0);
    check("t4_count", count, 4);
    check("t4_ovf", overflow, 1);
    for (int i = 0; i < 4; i++) cyc();
    comp_ready = 1'b0;
    check("t4_count_drained", count, 0);
    check("t4_valid_drained", comp_valid, 0);

    cyc();
    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
